// File: rtl/ring_mon_pkg.sv
// ring_mon_pkg: shared types and helpers for the ring phase monitor.
//   state_e    - lock/fault state machine encoding
//   next_idx   - index of the legal successor of a hot bit (moves toward LSB, wraps)
//   is_onehot  - true when exactly one bit of a (zero-extended) vector is set
package ring_mon_pkg;

  // Widest ring vector the helpers accept; narrower vectors are zero-extended.
  localparam int unsigned MaxWidth = 64;

  typedef enum logic [1:0] {
    StSearch,
    StAcquire,
    StLocked,
    StFault
  } state_e;

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned width);
    return (idx == 0) ? width - 1 : idx - 1;
  endfunction

  // vec & (vec - 1) clears the lowest set bit; zero afterwards means at most one bit was set.
  function automatic logic is_onehot(input logic [MaxWidth-1:0] vec);
    return (vec != '0) && ((vec & (vec - MaxWidth'(1))) == '0);
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// ring_onehot_enc: combinational one-hot to binary encoder.
//   vec_i    - ring vector to encode
//   idx_o    - binary index of the hot bit, 0 when vec_i is not one-hot
//   onehot_o - vec_i has exactly one bit set
module ring_onehot_enc
  import ring_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]         vec_i,
  output logic [$clog2(WIDTH)-1:0] idx_o,
  output logic                     onehot_o
);

  localparam int unsigned IdxW = $clog2(WIDTH);

  logic [MaxWidth-1:0] vec_ext;

  always_comb begin
    vec_ext              = '0;
    vec_ext[WIDTH-1:0]   = vec_i;
    onehot_o             = is_onehot(vec_ext);
    idx_o                = '0;
    // OR of set-bit indices; exact only for one-hot inputs, forced to 0 otherwise.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (vec_i[i]) begin
        idx_o = idx_o | IdxW'(i);
      end
    end
    if (!onehot_o) begin
      idx_o = '0;
    end
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: checks a one-hot ring counter, encodes its phase and tracks lock health.
// Optional feature macro: RING_MON_STALL_EN (a repeated one-hot sample is a legal stall).
// Ports:
//   clk         - clock, all flops on rising edge
//   reset       - asynchronous active-low reset
//   ring_in     - one-hot ring vector (changes on falling clk edge)
//   clear       - synchronous: return to search and zero rev_count
//   phase       - binary index of the hot bit, 0 when not valid
//   phase_valid - phase is trustworthy this cycle
//   locked      - monitor is locked to the ring
//   wrap        - one-cycle pulse on a locked step into index 0
//   rev_count   - completed revolutions while locked (wraps silently)
//   error       - one-cycle pulse on an illegal step while locked
//   fault       - monitor is in the fault state
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_COUNT = 2,
  parameter int unsigned REV_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     clear,
  output logic [$clog2(WIDTH)-1:0] phase,
  output logic                     phase_valid,
  output logic                     locked,
  output logic                     wrap,
  output logic [REV_W-1:0]         rev_count,
  output logic                     error,
  output logic                     fault
);

  localparam int unsigned PhaseW = $clog2(WIDTH);
  localparam int unsigned CntW   = $clog2(LOCK_COUNT + 1);

  // Pipeline: r_ring is the current sample, p_ring/p_idx describe the previous one.
  logic [WIDTH-1:0]    r_ring_q, p_ring_q;
  logic [PhaseW-1:0]   p_idx_q;

  state_e              state_q, state_d;
  logic [CntW-1:0]     good_cnt_q, good_cnt_d;
  logic [REV_W-1:0]    rev_count_q, rev_count_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic                phase_valid_q, phase_valid_d;
  logic                locked_q, locked_d;
  logic                wrap_q, wrap_d;
  logic                error_q, error_d;
  logic                fault_q, fault_d;

  logic [PhaseW-1:0]   cur_idx;
  logic                cur_oh;
  logic [MaxWidth-1:0] p_ext;
  logic                prev_oh;
  logic [PhaseW-1:0]   succ_idx;
  logic                step_legal;
  logic                step_stall;

  ring_onehot_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .vec_i    (r_ring_q),
    .idx_o    (cur_idx),
    .onehot_o (cur_oh)
  );

  always_comb begin
    p_ext              = '0;
    p_ext[WIDTH-1:0]   = p_ring_q;
    prev_oh            = is_onehot(p_ext);
    succ_idx           = PhaseW'(next_idx(32'(p_idx_q), WIDTH));
    step_legal         = cur_oh && prev_oh && (cur_idx == succ_idx);
`ifdef RING_MON_STALL_EN
    step_stall         = cur_oh && prev_oh && (r_ring_q == p_ring_q);
`else
    step_stall         = 1'b0;
`endif
  end

  // Next-state logic. clear has priority over every step classification.
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    rev_count_d = rev_count_q;
    wrap_d      = 1'b0;
    error_d     = 1'b0;

    if (clear) begin
      state_d     = StSearch;
      good_cnt_d  = '0;
      rev_count_d = '0;
    end else begin
      unique case (state_q)
        StSearch: begin
          // First one-hot sample only sets the reference index.
          if (cur_oh) begin
            state_d    = StAcquire;
            good_cnt_d = '0;
          end
        end
        StAcquire: begin
          if (!step_stall) begin
            if (step_legal) begin
              good_cnt_d = good_cnt_q + CntW'(1);
              if (good_cnt_q == CntW'(LOCK_COUNT - 1)) begin
                state_d = StLocked;
              end
            end else begin
              state_d    = StSearch;
              good_cnt_d = '0;
            end
          end
        end
        StLocked: begin
          if (!step_stall) begin
            if (step_legal) begin
              if (cur_idx == '0) begin
                wrap_d      = 1'b1;
                rev_count_d = rev_count_q + REV_W'(1);
              end
            end else begin
              state_d = StFault;
              error_d = 1'b1;
            end
          end
        end
        StFault: begin
          state_d = StFault;
        end
        default: begin
          state_d = StSearch;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the evaluated sample.
  always_comb begin
    phase_valid_d = ((state_d == StAcquire) || (state_d == StLocked)) && cur_oh;
    phase_d       = phase_valid_d ? cur_idx : '0;
    locked_d      = (state_d == StLocked);
    fault_d       = (state_d == StFault);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ring_q      <= '0;
      p_ring_q      <= '0;
      p_idx_q       <= '0;
      state_q       <= StSearch;
      good_cnt_q    <= '0;
      rev_count_q   <= '0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      wrap_q        <= 1'b0;
      error_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      r_ring_q      <= ring_in;
      p_ring_q      <= r_ring_q;
      p_idx_q       <= cur_idx;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      rev_count_q   <= rev_count_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      locked_q      <= locked_d;
      wrap_q        <= wrap_d;
      error_q       <= error_d;
      fault_q       <= fault_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign locked      = locked_q;
  assign wrap        = wrap_q;
  assign rev_count   = rev_count_q;
  assign error       = error_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor: directed self-checking bench for ring_phase_monitor.
// A second instance with REV_W=2 shares all stimulus to exercise revolution counter wrap.
module tb_ring_phase_monitor;

  logic       clk;
  logic       reset;
  logic [3:0] ring_in;
  logic       clear;

  logic [1:0] phase, w2_phase;
  logic       phase_valid, w2_phase_valid;
  logic       locked, w2_locked;
  logic       wrap, w2_wrap;
  logic [7:0] rev_count;
  logic [1:0] w2_rev_count;
  logic       error, w2_error;
  logic       fault, w2_fault;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0] vec;
    logic       clr;
    int         ph;
    logic       pv;
    logic       lk;
    logic       wr;
    int         rev;
    logic       er;
    logic       ft;
  } entry_t;

  entry_t tbl[$];

  ring_phase_monitor #(
    .WIDTH      (4),
    .LOCK_COUNT (2),
    .REV_W      (8)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .ring_in     (ring_in),
    .clear       (clear),
    .phase       (phase),
    .phase_valid (phase_valid),
    .locked      (locked),
    .wrap        (wrap),
    .rev_count   (rev_count),
    .error       (error),
    .fault       (fault)
  );

  ring_phase_monitor #(
    .WIDTH      (4),
    .LOCK_COUNT (2),
    .REV_W      (2)
  ) u_dut_w2 (
    .clk         (clk),
    .reset       (reset),
    .ring_in     (ring_in),
    .clear       (clear),
    .phase       (w2_phase),
    .phase_valid (w2_phase_valid),
    .locked      (w2_locked),
    .wrap        (w2_wrap),
    .rev_count   (w2_rev_count),
    .error       (w2_error),
    .fault       (w2_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [3:0] vec, input logic clr, input int ph, input logic pv,
                     input logic lk, input logic wr, input int rev, input logic er,
                     input logic ft);
    entry_t e;
    e.vec = vec; e.clr = clr; e.ph = ph; e.pv = pv; e.lk = lk;
    e.wr = wr; e.rev = rev; e.er = er; e.ft = ft;
    tbl.push_back(e);
  endtask

  task automatic check_entry(input string tag, input entry_t e);
    check_eq({tag, ".phase"},     32'(phase),        32'(e.ph));
    check_eq({tag, ".valid"},     32'(phase_valid),  32'(e.pv));
    check_eq({tag, ".locked"},    32'(locked),       32'(e.lk));
    check_eq({tag, ".wrap"},      32'(wrap),         32'(e.wr));
    check_eq({tag, ".rev"},       32'(rev_count),    32'(e.rev));
    check_eq({tag, ".error"},     32'(error),        32'(e.er));
    check_eq({tag, ".fault"},     32'(fault),        32'(e.ft));
    check_eq({tag, ".w2_wrap"},   32'(w2_wrap),      32'(e.wr));
    check_eq({tag, ".w2_rev"},    32'(w2_rev_count), 32'(e.rev % 4));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ".phase"},  32'(phase),        0);
    check_eq({tag, ".valid"},  32'(phase_valid),  0);
    check_eq({tag, ".locked"}, 32'(locked),       0);
    check_eq({tag, ".wrap"},   32'(wrap),         0);
    check_eq({tag, ".rev"},    32'(rev_count),    0);
    check_eq({tag, ".error"},  32'(error),        0);
    check_eq({tag, ".fault"},  32'(fault),        0);
    check_eq({tag, ".w2_rev"}, 32'(w2_rev_count), 0);
  endtask

  // Sample i is driven on negedge i; its outputs are visible at negedge i+2.
  // clear for entry i is driven alongside sample i+1 so it meets the edge evaluating entry i.
  task automatic run_table(input string name);
    int n;
    n = tbl.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) check_entry($sformatf("%s[%0d]", name, i - 2), tbl[i-2]);
      if (i < n) ring_in = tbl[i].vec;
      else       ring_in = {ring_in[0], ring_in[3:1]};
      clear = 1'b0;
      if (i >= 1 && i <= n) clear = tbl[i-1].clr;
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    ring_in = 4'b0000;
    clear   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    ring_in = 4'b0000;
    clear   = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;

    // Clean lock, corruption while locked, fault hold, clear, acquire miss.
    add(4'b0001, 0, 0, 1, 0, 0, 0, 0, 0);
    add(4'b1000, 0, 3, 1, 0, 0, 0, 0, 0);
    add(4'b0100, 0, 2, 1, 1, 0, 0, 0, 0);
    add(4'b0010, 0, 1, 1, 1, 0, 0, 0, 0);
    add(4'b0001, 0, 0, 1, 1, 1, 1, 0, 0);
    add(4'b1000, 0, 3, 1, 1, 0, 1, 0, 0);
    add(4'b0011, 0, 0, 0, 0, 0, 1, 1, 1);
    add(4'b0100, 0, 0, 0, 0, 0, 1, 0, 1);
    add(4'b0010, 0, 0, 0, 0, 0, 1, 0, 1);
    add(4'b0001, 1, 0, 0, 0, 0, 0, 0, 0);
    add(4'b0001, 0, 0, 1, 0, 0, 0, 0, 0);
    add(4'b1000, 0, 3, 1, 0, 0, 0, 0, 0);
    add(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0);
    add(4'b0001, 0, 0, 1, 0, 0, 0, 0, 0);
    run_table("lock_fault_miss");

    // Repeated sample while locked at 0100.
    do_reset();
    add(4'b0001, 0, 0, 1, 0, 0, 0, 0, 0);
    add(4'b1000, 0, 3, 1, 0, 0, 0, 0, 0);
    add(4'b0100, 0, 2, 1, 1, 0, 0, 0, 0);
`ifdef RING_MON_STALL_EN
    add(4'b0100, 0, 2, 1, 1, 0, 0, 0, 0);
    add(4'b0100, 0, 2, 1, 1, 0, 0, 0, 0);
    add(4'b0010, 0, 1, 1, 1, 0, 0, 0, 0);
`else
    add(4'b0100, 0, 0, 0, 0, 0, 0, 1, 1);
    add(4'b0100, 0, 0, 0, 0, 0, 0, 0, 1);
    add(4'b0010, 0, 0, 0, 0, 0, 0, 0, 1);
`endif
    run_table("stall");

    // Five locked revolutions; the REV_W=2 instance sees 1,2,3,0,1.
    do_reset();
    add(4'b0001, 0, 0, 1, 0, 0, 0, 0, 0);
    add(4'b1000, 0, 3, 1, 0, 0, 0, 0, 0);
    add(4'b0100, 0, 2, 1, 1, 0, 0, 0, 0);
    add(4'b0010, 0, 1, 1, 1, 0, 0, 0, 0);
    add(4'b0001, 0, 0, 1, 1, 1, 1, 0, 0);
    for (int r = 1; r <= 4; r++) begin
      add(4'b1000, 0, 3, 1, 1, 0, r,     0, 0);
      add(4'b0100, 0, 2, 1, 1, 0, r,     0, 0);
      add(4'b0010, 0, 1, 1, 1, 0, r,     0, 0);
      add(4'b0001, 0, 0, 1, 1, 1, r + 1, 0, 0);
    end
    run_table("revs");

    // Asynchronous reset between clock edges while locked.
    #2;
    reset = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    ring_in = 4'b0000;
    @(negedge clk);
    reset = 1'b1;

    // Full reacquire from an arbitrary phase, then clear beating an illegal step.
    add(4'b1000, 0, 3, 1, 0, 0, 0, 0, 0);
    add(4'b0100, 0, 2, 1, 0, 0, 0, 0, 0);
    add(4'b0010, 0, 1, 1, 1, 0, 0, 0, 0);
    add(4'b0001, 0, 0, 1, 1, 1, 1, 0, 0);
    add(4'b0011, 1, 0, 0, 0, 0, 0, 0, 0);
    add(4'b1000, 0, 3, 1, 0, 0, 0, 0, 0);
    run_table("reacquire");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
